// File: rtl/fetch_unit.sv
// SEQ fetch stage: reads one instruction byte-by-byte over a req/ack handshake and decodes it.
// Optional FETCH_TIMEOUT_EN bounds the wait for mem_ack on each byte.
module fetch_unit #(
    parameter int unsigned MEM_SIZE       = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] pc_in,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [1:0]  stat
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    state_t      state, state_next;
    logic [63:0] pc;
    logic [3:0]  idx;
    logic [3:0]  len;
    logic [3:0]  cur_len;
    logic [63:0] cur_addr;
    logic        addr_bad;
    logic        xfer;
    logic        last;
    logic        timeout_hit;
    logic [2:0]  cbyte;
    logic        is_const_byte;

    function automatic logic [3:0] ins_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:             ins_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB:       ins_len = 4'd2;
            4'h7, 4'h8:                   ins_len = 4'd9;
            4'h3, 4'h4, 4'h5:             ins_len = 4'd10;
            default:                      ins_len = 4'd1;
        endcase
    endfunction

    function automatic logic has_reg(input logic [3:0] ic);
        has_reg = (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
    endfunction

    assign cur_addr = pc + {60'd0, idx};
    assign addr_bad = (cur_addr >= 64'(MEM_SIZE));
    assign mem_addr = cur_addr;
    assign xfer     = mem_req && mem_ack;
    // Length is only known once byte 0 is on the bus; later bytes use the latched value.
    assign cur_len  = (idx == 4'd0) ? ins_len(mem_rdata[7:4]) : len;
    assign last     = ((idx + 4'd1) == cur_len);

    // Constant bytes start at byte 1 for jXX/call and at byte 2 for the register-carrying forms.
    always_comb begin
        cbyte         = 3'd0;
        is_const_byte = 1'b0;
        if (icode == 4'h7 || icode == 4'h8) begin
            cbyte         = 3'(idx - 4'd1);
            is_const_byte = (idx >= 4'd1);
        end else if (icode inside {4'h3, 4'h4, 4'h5}) begin
            cbyte         = 3'(idx - 4'd2);
            is_const_byte = (idx >= 4'd2);
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wait_cnt;

    assign timeout_hit = (state == REQ) && !addr_bad && !mem_ack &&
                         (wait_cnt == WW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if ((state == IDLE && start) || xfer) begin
            wait_cnt <= '0;
        end else if (state == REQ && !addr_bad) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = REQ;
            REQ: begin
                if (addr_bad)                state_next = DONE;
                else if (xfer && last)       state_next = DONE;
                else if (timeout_hit)        state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: handshake outputs decode the state register directly, so an async reset drops mem_req at once.
    always_comb begin
        mem_req = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            REQ: begin
                mem_req = !addr_bad;
                busy    = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= '0;
            idx   <= '0;
            len   <= 4'd1;
            icode <= 4'h0;
            ifun  <= 4'h0;
            rA    <= 4'hF;
            rB    <= 4'hF;
            valC  <= '0;
            valP  <= '0;
            stat  <= STAT_AOK;
        end else if (state == IDLE && start) begin
            pc    <= pc_in;
            idx   <= '0;
            len   <= 4'd1;
            icode <= 4'h0;
            ifun  <= 4'h0;
            rA    <= 4'hF;
            rB    <= 4'hF;
            valC  <= '0;
            valP  <= pc_in + 64'd1;
            stat  <= STAT_AOK;
        end else if (state == REQ) begin
            if (addr_bad || timeout_hit) begin
                stat <= STAT_ADR;
            end else if (xfer) begin
                idx <= idx + 4'd1;
                if (idx == 4'd0) begin
                    icode <= mem_rdata[7:4];
                    ifun  <= mem_rdata[3:0];
                    len   <= cur_len;
                    valP  <= pc + {60'd0, cur_len};
                    if (mem_rdata[7:4] > 4'hB)       stat <= STAT_INS;
                    else if (mem_rdata[7:4] == 4'h0) stat <= STAT_HLT;
                    else                             stat <= STAT_AOK;
                end else if (idx == 4'd1 && has_reg(icode)) begin
                    rA <= mem_rdata[7:4];
                    rB <= mem_rdata[3:0];
                end else if (is_const_byte) begin
                    valC[{cbyte, 3'b000} +: 8] <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected decodes, a monitor pops them on done.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] pc_in;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        done;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic [1:0]  stat;

    fetch_unit #(.MEM_SIZE(4096), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .pc_in(pc_in),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .stat(stat)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic [1:0]  stat;
        int          nxfer;
        int          lat;
        int          start_cyc;
        int          xfer_base;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passed = 0;

    logic [7:0] mem [0:4095];
    int ack_delay = 0;
    int wcnt = 0;
    int cyc = 0;
    int xfer_total = 0;
    int bad_reqs = 0;

    assign mem_ack   = mem_req && (wcnt >= ack_delay);
    assign mem_rdata = (mem_addr < 64'd4096) ? mem[mem_addr[11:0]] : 8'h00;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
        if (mem_req && mem_ack) xfer_total <= xfer_total + 1;
    end

    always @(negedge clk)
        if (mem_req && mem_addr >= 64'd4096) bad_reqs <= bad_reqs + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Monitor: compare every done pulse against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, ".icode"}, 64'(icode), 64'(e.icode));
                check({e.name, ".ifun"},  64'(ifun),  64'(e.ifun));
                check({e.name, ".rA"},    64'(rA),    64'(e.ra));
                check({e.name, ".rB"},    64'(rB),    64'(e.rb));
                check({e.name, ".valC"},  valC,       e.valc);
                check({e.name, ".valP"},  valP,       e.valp);
                check({e.name, ".stat"},  64'(stat),  64'(e.stat));
                check({e.name, ".xfers"}, 64'(xfer_total - e.xfer_base), 64'(e.nxfer));
                check({e.name, ".latency"}, 64'(cyc - e.start_cyc), 64'(e.lat));
                check({e.name, ".busy_low"}, 64'(busy), 64'd0);
            end
        end
    end

    task automatic issue(input exp_t e, input logic [63:0] pc);
        @(negedge clk);
        pc_in       = pc;
        start       = 1'b1;
        e.start_cyc = cyc + 1;
        e.xfer_base = xfer_total;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            check({name, ".done_timeout"}, 64'(q.size()), 64'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    function automatic exp_t mk(input string n, input logic [3:0] ic, input logic [3:0] fn,
                                input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc,
                                input logic [63:0] vp, input logic [1:0] st, input int nx, input int lat);
        exp_t e;
        e.name = n; e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb; e.valc = vc; e.valp = vp;
        e.stat = st; e.nxfer = nx; e.lat = lat; e.start_cyc = 0; e.xfer_base = 0;
        return e;
    endfunction

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h000] = 8'h10;
        mem[12'h100] = 8'h30; mem[12'h101] = 8'hF3;
        for (int i = 0; i < 8; i++) mem[12'h102 + i] = 8'(8 - i);
        mem[12'h020] = 8'h70; mem[12'h021] = 8'h40;
        mem[12'h030] = 8'hC0; mem[12'h031] = 8'h00;
        mem[12'h040] = 8'h61; mem[12'h041] = 8'h23;
        mem[12'h050] = 8'h10;
        mem[4090] = 8'h50; mem[4091] = 8'h12;
        mem[4092] = 8'h11; mem[4093] = 8'h22; mem[4094] = 8'h33; mem[4095] = 8'h44;

        rst = 1'b1; start = 1'b0; pc_in = '0;
        repeat (2) @(negedge clk);
        check("reset.mem_req", 64'(mem_req), 64'd0);
        check("reset.busy",    64'(busy),    64'd0);
        check("reset.done",    64'(done),    64'd0);
        check("reset.rA",      64'(rA),      64'hF);
        check("reset.rB",      64'(rB),      64'hF);
        check("reset.valP",    valP,         64'd0);
        check("reset.stat",    64'(stat),    64'd0);
        rst = 1'b0;
        @(negedge clk);

        ack_delay = 0;
        issue(mk("nop", 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 2'd0, 1, 1), 64'h0);
        wait_drain("nop");

        ack_delay = 2;
        issue(mk("irmovq", 4'h3, 4'h0, 4'hF, 4'h3, 64'h0102030405060708, 64'h10A, 2'd0, 10, 30), 64'h100);
        repeat (3) @(negedge clk);
        pc_in = 64'h0; start = 1'b1;          // must be ignored while busy
        @(negedge clk);
        start = 1'b0;
        wait_drain("irmovq");

        ack_delay = 0;
        issue(mk("jmp", 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'h29, 2'd0, 9, 9), 64'h20);
        wait_drain("jmp");

        issue(mk("invalid", 4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'h31, 2'd3, 1, 1), 64'h30);
        wait_drain("invalid");

        issue(mk("halt", 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h32, 2'd1, 1, 1), 64'h31);
        wait_drain("halt");

        ack_delay = 1;
        issue(mk("opq", 4'h6, 4'h1, 4'h2, 4'h3, 64'd0, 64'h42, 2'd0, 2, 4), 64'h40);
        wait_drain("opq");

        ack_delay = 0;
        issue(mk("adr_edge", 4'h5, 4'h0, 4'h1, 4'h2, 64'h44332211, 64'd4100, 2'd2, 6, 7), 64'd4090);
        wait_drain("adr_edge");
        check("no_req_past_end", 64'(bad_reqs), 64'd0);

        // Reset mid-fetch: no done is expected for this start.
        ack_delay = 2;
        begin
            int base;
            @(negedge clk);
            base  = xfer_total;
            pc_in = 64'h100; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 100 && (xfer_total - base) < 3; i++) @(negedge clk);
            check("abort.reached_byte3", 64'(xfer_total - base), 64'd3);
            #2 rst = 1'b1;
            #1;
            check("abort.mem_req", 64'(mem_req), 64'd0);
            check("abort.busy",    64'(busy),    64'd0);
            check("abort.stat",    64'(stat),    64'd0);
            check("abort.rB",      64'(rB),      64'hF);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            check("abort.idle_done", 64'(done), 64'd0);
        end

`ifdef FETCH_TIMEOUT_EN
        ack_delay = 1000;
        issue(mk("timeout", 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h51, 2'd2, 0, 16), 64'h50);
        wait_drain("timeout");
        ack_delay = 0;
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- SEQ fetch stage; sits directly downstream of pc_update and consumes PC_new as its pc_in.
- On each start pulse it reads the instruction at pc_in from byte-wide instruction memory over a req/ack handshake, one byte per transfer.
- Decodes icode, ifun, rA, rB, valC and valP and reports status.
- Its outputs feed decode/execute, which later produce the cnd, valC, valM and valP values that pc_update consumes.

Parameters:
- MEM_SIZE, 4096, instruction memory size in bytes; legal addresses are 0..MEM_SIZE-1.
- TIMEOUT_CYCLES, 16, maximum cycles to wait for mem_ack on one byte; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse: latch pc_in and begin a fetch.
- pc_in  in  64  PC to fetch from (PC_new from pc_update).
- mem_req  out  1  byte read request.
- mem_addr  out  64  byte address of the current request.
- mem_ack  in  1  memory accepts the request; mem_rdata is valid in the same cycle.
- mem_rdata  in  8  read byte.
- busy  out  1  fetch in progress.
- done  out  1  one-cycle pulse; decoded fields valid from this cycle until the next start.
- icode  out  4  instruction code.
- ifun  out  4  function code.
- rA  out  4  register A; 4'hF if the instruction has no register byte.
- rB  out  4  register B; 4'hF if the instruction has no register byte.
- valC  out  64  constant, little-endian; 0 if absent.
- valP  out  64  pc_in + instruction length.
- stat  out  2  0=AOK, 1=HLT, 2=ADR, 3=INS.

Behaviour:
- Reset (asynchronous): state IDLE; mem_req=0, busy=0, done=0; all data outputs 0; rA=rB=4'hF; stat=AOK. Reset asserted mid-fetch aborts immediately and mem_req drops without waiting for a clock.
- FSM states:
  - IDLE: start=1 latches pc_in and loads byte counter idx=0, then goes to REQ. busy=1 from the next cycle.
  - REQ: mem_req=1, mem_addr=PC+idx, both stable until ack.
    - A transfer occurs on each rising edge with mem_req && mem_ack.
    - After a transfer, idx increments and the next address is presented the following cycle with mem_req still high.
    - After the last byte, go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- start while busy is ignored.
- Zero-wait memory (ack tied high): done rises at edge N+len, where start is sampled at edge N.
- Length is decided from byte 0:
  - halt(0), nop(1), ret(9): 1 byte.
  - rrmovq/cmovXX(2), OPq(6), pushq(A), popq(B): 2 bytes.
  - jXX(7), call(8): 9 bytes; valC from bytes 1..8.
  - irmovq(3), rmmovq(4), mrmovq(5): 10 bytes; valC from bytes 2..9.
  - Byte 1 gives rA = high nibble, rB = low nibble.
- Invalid icode (>4'hB): stop after byte 0; stat=INS; valP=PC+1.
- halt: stat=HLT after its single byte.
- Address check before each request: if PC+idx >= MEM_SIZE, no request is issued and the FSM goes straight to DONE. Output fields are:
  - stat=ADR.
  - Already-fetched fields retained.
  - valP=PC+full length, or PC+1 if icode is unknown.
- Address arithmetic is 64-bit unsigned and wraps. A wrapped address is >= MEM_SIZE only if numerically so; no special wrap handling.
- Status priority when several apply: ADR > INS > HLT > AOK.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- When defined: a wait counter clears on every transfer and on start, and increments each REQ cycle without ack. On reaching TIMEOUT_CYCLES, the FSM drops mem_req, goes to DONE and sets stat=ADR.
- When undefined: no counter; the FSM waits for mem_ack indefinitely.

Test Plan:
- Reset, then start with pc_in=0; memory holds byte 0x10, ack tied high -> done at edge+1; icode=1, rA=rB=F, valP=1, stat=AOK.
- pc_in=0x100; bytes 30 F3 then 08 07 06 05 04 03 02 01; ack delayed 2 cycles per byte -> icode=3, rB=3, valC=0x0102030405060708, valP=0x10A, 10 transfers.
- pc_in=0x20; bytes 70 then 0x40,0,...,0 -> icode=7, ifun=0, valC=0x40, valP=0x29.
- pc_in=0x30; byte 0xC0 -> single transfer, stat=INS, valP=0x31; pc_in=0x31; byte 0x00 -> stat=HLT.
- MEM_SIZE=4096, pc_in=4090, mrmovq -> 6 transfers, no request to 4096, stat=ADR, valP=4100.
- rst pulsed during byte 3 of an irmovq -> mem_req=0 asynchronously, busy=0, stat=AOK. With FETCH_TIMEOUT_EN and ack held low -> done after 16 wait cycles, stat=ADR.
